// File: rtl/instr_encoder_if.sv
// Request handshake and instruction-memory write bus of the RV32I program writer.
interface instr_encoder_if #(
   parameter int ADDR_WIDTH = 6
);
   logic                  in_valid;
   logic                  in_ready;
   logic [3:0]            in_op;
   logic [4:0]            in_rd;
   logic [4:0]            in_rs1;
   logic [4:0]            in_rs2;
   logic [11:0]           in_imm;
   logic                  in_last;
   logic                  mem_write_enable;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [31:0]           mem_write_data;

   modport master (
      output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
      input  in_ready, mem_write_enable, mem_address, mem_write_data
   );

   modport slave (
      input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
      output in_ready, mem_write_enable, mem_address, mem_write_data
   );
endinterface

// File: rtl/instr_encoder.sv
// RV32I field-level encoder: assembles machine words from op/register/immediate
// fields and writes them sequentially into instruction memory from address 0.
module instr_encoder #(
   parameter int ADDR_WIDTH = 6
) (
   input  logic              clock,
   input  logic              reset,
   instr_encoder_if.slave    bus,
   output logic [ADDR_WIDTH:0] count,
   output logic              done,
   output logic              error
);

   typedef enum logic [1:0] {IDLE, WRITE, DONE, ERROR} state_t;

   localparam logic [ADDR_WIDTH:0] LAST_CNT = {1'b0, {ADDR_WIDTH{1'b1}}};

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_p1;
   logic [31:0]           word_p1;
   logic                  last_p1;
   logic                  accept;
   logic                  op_legal;

   function automatic logic [31:0] encode(input logic [3:0]  op,
                                          input logic [4:0]  rd,
                                          input logic [4:0]  rs1,
                                          input logic [4:0]  rs2,
                                          input logic [11:0] imm);
      logic [31:0] w;
      case (op)
         4'd0:    w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
         4'd1:    w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
         4'd2:    w = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
         4'd3:    w = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
         4'd4:    w = {7'b0000000, rs2, rs1, 3'b010, rd, 7'b0110011};
         4'd5:    w = {imm, rs1, 3'b000, rd, 7'b0010011};
         4'd6:    w = {imm, rs1, 3'b111, rd, 7'b0010011};
         4'd7:    w = {imm, rs1, 3'b110, rd, 7'b0010011};
         4'd8:    w = {imm, rs1, 3'b010, rd, 7'b0010011};
         4'd9:    w = {imm, rs1, 3'b010, rd, 7'b0000011};
         4'd10:   w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
         // imm holds offset[12:1], so offset bit n sits at imm bit n-1
         4'd11:   w = {imm[11], imm[9:4], rs2, rs1, 3'b000, imm[3:0], imm[10], 7'b1100011};
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   assign op_legal = (bus.in_op <= 4'd11);
   assign accept   = (state_q == IDLE) && bus.in_valid;

   // state register
   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = op_legal ? WRITE : ERROR;
         WRITE:   state_d = (last_p1 || count == LAST_CNT) ? DONE : IDLE;
         DONE:    state_d = DONE;
         ERROR:   state_d = ERROR;
         default: state_d = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      bus.in_ready         = 1'b0;
      bus.mem_write_enable = 1'b0;
      done                 = 1'b0;
      error                = 1'b0;
      case (state_q)
         IDLE:    bus.in_ready         = 1'b1;
         WRITE:   bus.mem_write_enable = 1'b1;
         DONE:    done                 = 1'b1;
         ERROR:   error                = 1'b1;
         default: bus.in_ready         = 1'b0;
      endcase
   end

   // encode stage: address and word captured at acceptance, held until the next one
   always_ff @(posedge clock) begin
      if (reset) begin
         addr_p1 <= '0;
         word_p1 <= '0;
         last_p1 <= 1'b0;
      end else if (accept && op_legal) begin
         addr_p1 <= count[ADDR_WIDTH-1:0];
         word_p1 <= encode(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
         last_p1 <= bus.in_last;
      end
   end

   always_ff @(posedge clock) begin
      if (reset)                 count <= '0;
      else if (state_q == WRITE) count <= count + 1'b1;
   end

   assign bus.mem_address    = addr_p1;
   assign bus.mem_write_data = word_p1;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, handshake timing, done/error,
// memory-full boundary and reset during a write.
module tb_instr_encoder;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   strobes1 = 0;

   logic [6:0] count1;
   logic       done1, error1;
   logic [2:0] count2;
   logic       done2, error2;

   instr_encoder_if #(.ADDR_WIDTH(6)) b1 ();
   instr_encoder_if #(.ADDR_WIDTH(2)) b2 ();

   instr_encoder #(.ADDR_WIDTH(6)) dut1 (
      .clock(clock), .reset(reset), .bus(b1),
      .count(count1), .done(done1), .error(error1)
   );

   instr_encoder #(.ADDR_WIDTH(2)) dut2 (
      .clock(clock), .reset(reset), .bus(b2),
      .count(count2), .done(done2), .error(error2)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (b1.mem_write_enable) strobes1 <= strobes1 + 1;

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   // Drives one request on b1; returns #1 after the accepting edge (DUT in WRITE).
   task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [11:0] imm, input logic last,
                       output bit ok);
      b1.in_op = op; b1.in_rd = rd; b1.in_rs1 = rs1; b1.in_rs2 = rs2;
      b1.in_imm = imm; b1.in_last = last; b1.in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clock);
         if (b1.in_ready === 1'b1) begin
            @(posedge clock);
            #1 ok = 1'b1;
         end
      end
      b1.in_valid = 1'b0;
      b1.in_last  = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (b1.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", b1.in_ready); end
      total++; if (b1.mem_write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", b1.mem_write_enable); end
      total++; if (b1.mem_address !== 6'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", b1.mem_address); end
      total++; if (b1.mem_write_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", b1.mem_write_data); end
      total++; if (count1 !== 7'd0 || done1 !== 1'b0 || error1 !== 1'b0) begin
         bad++; $display("FAIL reset_status got count=%0d done=%b error=%b want 0/0/0", count1, done1, error1); end
   endtask

   task automatic test_add();
      bit ok;
      do_reset();
      send(4'd0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0, ok);
      total++; if (!ok) begin bad++; $display("FAIL add_accept got=timeout want=accepted"); end
      total++; if (b1.mem_write_enable !== 1'b1 || b1.in_ready !== 1'b0) begin
         bad++; $display("FAIL add_strobe got we=%b ready=%b want we=1 ready=0", b1.mem_write_enable, b1.in_ready); end
      total++; if (b1.mem_address !== 6'd0 || b1.mem_write_data !== 32'h002081B3) begin
         bad++; $display("FAIL add_word got @%0d %h want @0 002081b3", b1.mem_address, b1.mem_write_data); end
      @(posedge clock); #1;
      total++; if (b1.in_ready !== 1'b1 || b1.mem_write_enable !== 1'b0 || count1 !== 7'd1) begin
         bad++; $display("FAIL add_after got ready=%b we=%b count=%0d want 1/0/1", b1.in_ready, b1.mem_write_enable, count1); end
      total++; if (b1.mem_address !== 6'd0 || b1.mem_write_data !== 32'h002081B3) begin
         bad++; $display("FAIL add_hold got @%0d %h want @0 002081b3", b1.mem_address, b1.mem_write_data); end
   endtask

   task automatic test_sub_addi();
      bit ok;
      do_reset();
      send(4'd1, 5'd5, 5'd6, 5'd7, 12'd0, 1'b0, ok);
      total++; if (!ok || b1.mem_address !== 6'd0 || b1.mem_write_data !== 32'h407302B3) begin
         bad++; $display("FAIL sub_word got ok=%b @%0d %h want @0 407302b3", ok, b1.mem_address, b1.mem_write_data); end
      send(4'd5, 5'd1, 5'd0, 5'd9, 12'hFFF, 1'b0, ok);
      total++; if (!ok || b1.mem_write_enable !== 1'b1 || b1.mem_address !== 6'd1 || b1.mem_write_data !== 32'hFFF00093) begin
         bad++; $display("FAIL addi_word got ok=%b we=%b @%0d %h want @1 fff00093", ok, b1.mem_write_enable, b1.mem_address, b1.mem_write_data); end
      @(posedge clock); #1;
      total++; if (count1 !== 7'd2) begin bad++; $display("FAIL sub_addi_count got=%0d want=2", count1); end
   endtask

   task automatic test_store_branch_last();
      bit ok;
      int s0;
      do_reset();
      send(4'd10, 5'd31, 5'd1, 5'd2, 12'd8, 1'b0, ok);
      total++; if (!ok || b1.mem_address !== 6'd0 || b1.mem_write_data !== 32'h0020A423) begin
         bad++; $display("FAIL sw_word got ok=%b @%0d %h want @0 0020a423", ok, b1.mem_address, b1.mem_write_data); end
      send(4'd11, 5'd17, 5'd1, 5'd2, 12'hFFC, 1'b1, ok);
      total++; if (!ok || b1.mem_address !== 6'd1 || b1.mem_write_data !== 32'hFE208CE3) begin
         bad++; $display("FAIL beq_word got ok=%b @%0d %h want @1 fe208ce3", ok, b1.mem_address, b1.mem_write_data); end
      @(posedge clock); #1;
      total++; if (done1 !== 1'b1 || b1.in_ready !== 1'b0 || count1 !== 7'd2) begin
         bad++; $display("FAIL last_done got done=%b ready=%b count=%0d want 1/0/2", done1, b1.in_ready, count1); end
      s0 = strobes1;
      b1.in_op = 4'd0; b1.in_valid = 1'b1;
      repeat (6) @(posedge clock);
      #1 b1.in_valid = 1'b0;
      total++; if (strobes1 !== s0 || done1 !== 1'b1 || count1 !== 7'd2) begin
         bad++; $display("FAIL done_ignores got strobes=%0d done=%b count=%0d want %0d/1/2", strobes1 - s0 + s0, done1, count1, s0); end
   endtask

   task automatic test_illegal_op();
      bit ok;
      int s0;
      do_reset();
      send(4'd0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0, ok);
      @(posedge clock); #1;
      s0 = strobes1;
      send(4'd13, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0, ok);
      total++; if (!ok || error1 !== 1'b1 || b1.in_ready !== 1'b0 || b1.mem_write_enable !== 1'b0) begin
         bad++; $display("FAIL bad_op got ok=%b error=%b ready=%b we=%b want 1/1/0/0", ok, error1, b1.in_ready, b1.mem_write_enable); end
      repeat (3) @(posedge clock); #1;
      total++; if (strobes1 !== s0 || count1 !== 7'd1 || done1 !== 1'b0 || error1 !== 1'b1) begin
         bad++; $display("FAIL bad_op_hold got strobes=%0d count=%0d done=%b error=%b want %0d/1/0/1", strobes1, count1, done1, error1, s0); end
      do_reset();
      total++; if (error1 !== 1'b0 || b1.in_ready !== 1'b1 || count1 !== 7'd0) begin
         bad++; $display("FAIL bad_op_reset got error=%b ready=%b count=%0d want 0/1/0", error1, b1.in_ready, count1); end
   endtask

   task automatic test_full();
      logic [31:0] exp_full [4];
      int k;
      exp_full = '{32'h000000B3, 32'h00000133, 32'h000001B3, 32'h00000233};
      do_reset();
      b2.in_op = 4'd0; b2.in_rs1 = 5'd0; b2.in_rs2 = 5'd0; b2.in_imm = 12'd0;
      b2.in_last = 1'b0; b2.in_rd = 5'd1; b2.in_valid = 1'b1;
      k = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clock);
         if (b2.mem_write_enable === 1'b1) begin
            if (k < 4) begin
               total++; if (b2.mem_address !== k[1:0] || b2.mem_write_data !== exp_full[k]) begin
                  bad++; $display("FAIL full_word%0d got @%0d %h want @%0d %h", k, b2.mem_address, b2.mem_write_data, k, exp_full[k]); end
            end
            k++;
            b2.in_rd = 5'(k + 1);
         end
      end
      b2.in_valid = 1'b0;
      total++; if (k !== 4) begin bad++; $display("FAIL full_strobes got=%0d want=4", k); end
      total++; if (done2 !== 1'b1 || count2 !== 3'd4 || b2.in_ready !== 1'b0) begin
         bad++; $display("FAIL full_done got done=%b count=%0d ready=%b want 1/4/0", done2, count2, b2.in_ready); end
   endtask

   task automatic test_reset_in_write();
      bit ok;
      do_reset();
      send(4'd0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0, ok);
      @(posedge clock); #1;
      send(4'd1, 5'd5, 5'd6, 5'd7, 12'd0, 1'b0, ok);
      total++; if (!ok || b1.mem_write_enable !== 1'b1 || b1.mem_address !== 6'd1) begin
         bad++; $display("FAIL rw_second got ok=%b we=%b @%0d want 1/1/@1", ok, b1.mem_write_enable, b1.mem_address); end
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      total++; if (b1.mem_write_enable !== 1'b0 || count1 !== 7'd0 || b1.in_ready !== 1'b1) begin
         bad++; $display("FAIL rw_abandon got we=%b count=%0d ready=%b want 0/0/1", b1.mem_write_enable, count1, b1.in_ready); end
      send(4'd5, 5'd1, 5'd0, 5'd0, 12'hFFF, 1'b0, ok);
      total++; if (!ok || b1.mem_address !== 6'd0 || b1.mem_write_data !== 32'hFFF00093) begin
         bad++; $display("FAIL rw_restart got ok=%b @%0d %h want @0 fff00093", ok, b1.mem_address, b1.mem_write_data); end
   endtask

   initial begin
      b1.in_valid = 1'b0; b1.in_op = 4'd0; b1.in_rd = 5'd0; b1.in_rs1 = 5'd0;
      b1.in_rs2 = 5'd0; b1.in_imm = 12'd0; b1.in_last = 1'b0;
      b2.in_valid = 1'b0; b2.in_op = 4'd0; b2.in_rd = 5'd0; b2.in_rs1 = 5'd0;
      b2.in_rs2 = 5'd0; b2.in_imm = 12'd0; b2.in_last = 1'b0;
      test_reset();
      test_add();
      test_sub_addi();
      test_store_branch_last();
      test_illegal_op();
      test_full();
      test_reset_in_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Field-level RV32I instruction encoder and program writer. It does the inverse job of the CPU's main and ALU decoders: it accepts an operation code plus register and immediate fields over a valid/ready handshake, and assembles the 32-bit machine word. Each word is written sequentially into instruction memory from address 0. It serves as the bench and boot-time program loader for the single-cycle CPU.

Parameters:
ADDR_WIDTH, 6, word-address width of instruction memory; capacity is 2^ADDR_WIDTH words.

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  request carries a valid instruction
in_ready  output  1  encoder can accept a request this cycle
in_op  input  4  operation select: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 addi, 6 andi, 7 ori, 8 slti, 9 lw, 10 sw, 11 beq; 12-15 illegal
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_imm  input  12  immediate; for beq this is byte offset[12:1]
in_last  input  1  this request is the final instruction of the program
mem_write_enable  output  1  one-cycle instruction-memory write strobe
mem_address  output  ADDR_WIDTH  word address of the write
mem_write_data  output  32  encoded instruction
count  output  ADDR_WIDTH+1  number of words written
done  output  1  program complete or memory full; sticky
error  output  1  illegal in_op received; sticky

Behaviour:
- Reset is synchronous and active-high, and takes priority over every other event.
- Reset values: state IDLE; in_ready=1; mem_write_enable=0; mem_address=0; mem_write_data=0; count=0; done=0; error=0.
- FSM states:
  - IDLE: in_ready=1. A transfer occurs when in_valid&&in_ready at a rising edge. Legal op -> register encoded word and in_last -> WRITE. Illegal op -> ERROR, nothing written.
  - WRITE: in_ready=0; mem_write_enable=1 for exactly this cycle; mem_address=current pointer. At the edge ending WRITE, pointer and count increment. If the latched last flag is set or count reaches 2^ADDR_WIDTH -> DONE, else -> IDLE.
  - DONE: in_ready=0, done=1, mem_write_enable=0. in_valid is ignored. Exit only by reset.
  - ERROR: in_ready=0, error=1, done=0. Exit only by reset.
- Latency and throughput: request accepted at edge N; write strobe asserted during cycle N+1; memory captures at edge N+1. Maximum throughput is 1 word per 2 cycles.
- mem_address and mem_write_data stay stable for the whole WRITE cycle. They hold their last values outside WRITE.
- Encodings, with opcode in bits [6:0]:
  - R-type 0110011, funct7 0000000; sub uses funct7 0100000. funct3: add/sub 000, slt 010, or 110, and 111.
  - I-ALU 0010011, imm[11:0] in bits [31:20]. funct3: addi 000, slti 010, ori 110, andi 111.
  - lw 0000011, funct3 010, I-format.
  - sw 0100011, funct3 010. Bits [31:25]=imm[11:5]; bits [11:7]=imm[4:0].
  - beq 1100011, funct3 000, with off=in_imm<<1. Bit31=off[12]; bits [30:25]=off[10:5]; bits [11:8]=off[4:1]; bit7=off[11].
  - Fields an op does not use (rd for sw/beq, rs2 for I-type) are ignored and do not appear in the word.
- Full boundary: the pointer does not wrap. The write at address 2^ADDR_WIDTH-1 forces DONE even when in_last=0.
- Reset asserted during WRITE: the write is abandoned. mem_write_enable=0 in the cycle after the reset edge; count=0.

Test Plan:
- Reset, then add rd=3 rs1=1 rs2=2 -> one strobe at mem_address 0, data 0x002081B3; count=1; in_ready low for 1 cycle.
- sub rd=5 rs1=6 rs2=7, then addi rd=1 rs1=0 imm=0xFFF -> data 0x407302B3 @0 and 0xFFF00093 @1; count=2.
- sw rs1=1 rs2=2 imm=8, then beq rs1=1 rs2=2 in_imm=0xFFC (offset -8) with in_last=1 -> 0x0020A423 @0, 0xFE208CE3 @1; done=1; in_ready=0; further in_valid produces no strobes.
- in_op=13 after one legal add -> error=1, no strobe for the bad op, count stays 1, in_ready=0. Reset -> error=0, in_ready=1, count=0.
- ADDR_WIDTH=2, in_valid held high with in_last=0, ops add rd=1..5 -> 4 strobes at addresses 0-3; done=1 after the 4th; count=4; 5th request never accepted.
- Reset asserted in the WRITE cycle of the second instruction -> no strobe in the next cycle; count=0. The next instruction is written at address 0.
